dmem_responder: RTL and testbench

//  Data-memory responder (slave end) for the CPU's MEM-stage load/store interface.

---
 rtl/dmem_resp_pkg.sv | 30 +++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types for the data-memory responder: access-width codes, FSM states
// and the rule for which width codes are legal for loads and stores.
package dmem_resp_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [2:0] {
        WHB_B  = 3'b000,
        WHB_H  = 3'b001,
        WHB_W  = 3'b010,
        WHB_BU = 3'b100,
        WHB_HU = 3'b101
    } whb_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Unsigned widths only make sense for loads; unused codes are always illegal.
    function automatic logic whb_illegal(input logic [2:0] whb, input logic we);
        case (whb)
            WHB_B, WHB_H, WHB_W: return 1'b0;
            WHB_BU, WHB_HU:      return we;
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request channel and response channel between the MEM stage
// (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_whb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_whb, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_whb, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, load lane
// extraction with sign/zero extension, and natural-alignment checking.
module dmem_lane_align
    import dmem_resp_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  whb,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wdata_shifted,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be            = '0;
        wdata_shifted = '0;
        rdata_ext     = '0;
        misaligned    = 1'b0;

        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        // Replicating the data into every lane lets the byte enables alone pick the target.
        case (whb)
            WHB_B, WHB_BU: begin
                be            = 4'b0001 << addr_lo;
                wdata_shifted = {4{wdata[7:0]}};
                rdata_ext     = (whb == WHB_B) ? {{24{byte_sel[7]}}, byte_sel}
                                               : {24'b0, byte_sel};
            end
            WHB_H, WHB_HU: begin
                be            = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_shifted = {2{wdata[15:0]}};
                rdata_ext     = (whb == WHB_H) ? {{16{half_sel[15]}}, half_sel}
                                               : {16'b0, half_sel};
                misaligned    = addr_lo[0];
            end
            WHB_W: begin
                be            = 4'b1111;
                wdata_shifted = wdata;
                rdata_ext     = word;
                misaligned    = (addr_lo != 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, committed at the accept
// edge, answered after LATENCY wait cycles on a valid/ready response channel.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int    DEPTH_WORDS  = 1024,
    parameter int    LATENCY      = 2,
    parameter string PROGRAM_DATA = ""
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int              IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0]     ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [LAT_W-1:0] LAT_INIT  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    logic [31:0] mem [DEPTH_WORDS];

    state_e           state;
    logic [LAT_W-1:0] count;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic [31:0]      pend_rdata_q;
    logic             pend_err_q;

    logic [IDX_W-1:0] word_idx;
    logic [31:0]      word_rd;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_rdata;
    logic             misaligned;
    logic             out_of_range;
    logic             req_err;
    logic             accept;
    logic             store_en;
    logic [31:0]      new_rdata;

    assign word_idx = bus.req_addr[IDX_W+1:2];
    assign word_rd  = mem[word_idx];

    dmem_lane_align u_lane_align (
        .addr_lo       (bus.req_addr[1:0]),
        .whb           (bus.req_whb),
        .wdata         (bus.req_wdata),
        .word          (word_rd),
        .be            (lane_be),
        .wdata_shifted (lane_wdata),
        .rdata_ext     (lane_rdata),
        .misaligned    (misaligned)
    );

    // A new request is taken from IDLE, or from RESP in the same cycle the old response leaves.
    assign bus.req_ready = rst && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));

    assign out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    assign req_err      = out_of_range || misaligned || whb_illegal(bus.req_whb, bus.req_we);
    assign accept       = bus.req_valid && bus.req_ready;
    assign store_en     = accept && bus.req_we && !req_err;
    assign new_rdata    = (req_err || bus.req_we) ? 32'h0 : lane_rdata;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // NOTE: the storage array is deliberately left out of reset so it maps onto plain RAM;
    // a store committed before a reset therefore survives it.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: all FSM state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        pend_rdata_q <= new_rdata;
                        pend_err_q   <= req_err;
                        if (LATENCY == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= new_rdata;
                            rsp_err_q   <= req_err;
                        end else begin
                            state       <= WAIT;
                            count       <= LAT_INIT;
                            rsp_valid_q <= 1'b0;
                        end
                    end else if ((state == RESP) && bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pend_rdata_q;
                        rsp_err_q   <= pend_err_q;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a byte-addressed
// reference memory that applies the access rules with plain arithmetic.
module tb_dmem_responder;

    localparam int          DEPTH_WORDS = 1024;
    localparam int          LATENCY     = 2;
    localparam logic [31:0] LIMIT       = 32'(4 * DEPTH_WORDS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS  (DEPTH_WORDS),
        .LATENCY      (LATENCY),
        .PROGRAM_DATA ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Reference: size from whb[1:0], signedness from whb[2], memory as loose bytes.
    function automatic void model(input logic we, input logic [2:0] whb, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
        int          size;
        logic [31:0] v;
        size  = 1 << whb[1:0];
        err   = (size == 8) || (whb[2] && (whb[1] || we)) ||
                ((addr % size) != 0) || (addr >= LIMIT);
        rdata = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v |= 32'(ref_mem[addr + 32'(i)]) << (8 * i);
            if (!whb[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 1);
            rdata = v;
        end
    endfunction

    // Called near a negedge; takes any held response in the same cycle.
    task automatic send(input logic we, input logic [2:0] whb, input logic [31:0] addr,
                        input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_whb   = whb;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = pending;
        #1 check("req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        pending       = 1'b0;
        model(we, whb, addr, wdata, exp_err, exp_rdata);
    endtask

    task automatic await_rsp(input string tag);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.rsp_valid && cycles < 20);
        check({tag, "_latency"}, 32'(cycles), 32'(LATENCY + 1));
        check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        pending = 1'b1;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
        check({tag, "_const_rdata"}, bus.rsp_rdata, rdata);
        check({tag, "_const_err"}, 32'(bus.rsp_err), 32'(err));
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        pending = 1'b0;
        @(negedge clk);
        check("rsp_gone", 32'(bus.rsp_valid), 32'd0);
        check("idle_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic hold(input int n);
        logic [31:0] d;
        logic        e;
        d = bus.rsp_rdata;
        e = bus.rsp_err;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_whb   = 3'b010;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h1234_5678;
        bus.rsp_ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata, d);
            check("hold_err", 32'(bus.rsp_err), 32'(e));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_whb   = 3'b010;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        pending       = 1'b0;
        rst           = 1'b0;

        // Reset: two edges with rst low and a request offered.
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1 check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        for (int w = 0; w < 16; w++) begin
            send(1'b1, 3'b010, 32'(4 * w), $urandom);
            await_rsp("init");
        end

        // Word store then load.
        send(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        await_rsp("sw");
        expect_rsp("sw", 32'h0, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        await_rsp("lw");
        expect_rsp("lw", 32'hDEAD_BEEF, 1'b0);
        release_rsp();

        // Byte store into a zeroed word, then signed/unsigned/word readback.
        send(1'b1, 3'b010, 32'h10, 32'h0);
        await_rsp("sw0");
        send(1'b1, 3'b000, 32'h13, 32'hABCD_EF80);
        await_rsp("sb");
        send(1'b0, 3'b000, 32'h13, 32'h0);
        await_rsp("lb");
        expect_rsp("lb", 32'hFFFF_FF80, 1'b0);
        send(1'b0, 3'b100, 32'h13, 32'h0);
        await_rsp("lbu");
        expect_rsp("lbu", 32'h0000_0080, 1'b0);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        await_rsp("lw_b");
        expect_rsp("lw_b", 32'h8000_0000, 1'b0);

        // Error cases.
        send(1'b0, 3'b001, 32'h11, 32'h0);
        await_rsp("lh_mis");
        expect_rsp("lh_mis", 32'h0, 1'b1);
        send(1'b1, 3'b010, 32'h12, 32'hFFFF_FFFF);
        await_rsp("sw_mis");
        expect_rsp("sw_mis", 32'h0, 1'b1);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        await_rsp("lw_keep");
        expect_rsp("lw_keep", 32'h8000_0000, 1'b0);
        send(1'b0, 3'b010, LIMIT, 32'h0);
        await_rsp("lw_oor");
        expect_rsp("lw_oor", 32'h0, 1'b1);
        send(1'b1, 3'b100, 32'h14, 32'h0);
        await_rsp("sbu_ill");
        expect_rsp("sbu_ill", 32'h0, 1'b1);

        // Backpressure, then a back-to-back accept as the response is taken.
        send(1'b0, 3'b001, 32'h12, 32'h0);
        await_rsp("bp");
        hold(5);
        send(1'b0, 3'b101, 32'h12, 32'h0);
        await_rsp("b2b");

        for (int n = 0; n < 300; n++) begin
            int r;
            if ($urandom_range(0, 2) == 0) release_rsp();
            r = $urandom_range(0, 9);
            if (r == 0)      a = LIMIT + 32'($urandom_range(0, 15));
            else if (r == 1) a = 32'hFFFF_FFFC;
            else             a = 32'($urandom_range(0, 63));
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            await_rsp("rand");
        end

        // Reset during WAIT: the load is dropped, the earlier store persists.
        send(1'b1, 3'b000, 32'h21, 32'h0000_005A);
        await_rsp("sb_pre");
        send(1'b0, 3'b010, 32'h24, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        rst     = 1'b1;
        pending = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
        end
        send(1'b0, 3'b000, 32'h21, 32'h0);
        await_rsp("lb_post");
        expect_rsp("lb_post", 32'h0000_005A, 1'b0);
        release_rsp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
